// File: rtl/bus_splitter_pkg.sv
// rtl/bus_splitter_pkg.sv - shared FSM encoding and width helper for bus_splitter
package bus_splitter_pkg;

  // Transaction phases: waiting for a request, forwarding to a server, answering the initiator
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// rtl/bus_addr_decoder.sv - maps the top address bits to a server index and its enable
module bus_addr_decoder
  import bus_splitter_pkg::*;
#(
  parameter int                         NR_OF_SERVERS = 4,
  parameter logic [NR_OF_SERVERS-1:0]   SERVER_EN     = '1,
  parameter int                         SEL_W         = width_of(NR_OF_SERVERS)
) (
  input  logic [SEL_W-1:0] region,
  output logic [SEL_W-1:0] sel,
  output logic             mapped
);

  // Regions are equal-sized, so the top address bits are the server index directly
  always_comb begin
    sel    = region;
    mapped = SERVER_EN[region];
  end

endmodule

// File: rtl/bus_splitter.sv
// rtl/bus_splitter.sv - one initiator fanned out to NR_OF_SERVERS responders with timeout
module bus_splitter
  import bus_splitter_pkg::*;
#(
  parameter int                        DATA_WIDTH    = 8,
  parameter int                        ADDR_WIDTH    = 4,
  parameter int                        NR_OF_SERVERS = 4,
  parameter logic [NR_OF_SERVERS-1:0]  SERVER_EN     = '1,
  parameter int                        TIMEOUT       = 15,
  parameter logic [DATA_WIDTH-1:0]     ERR_DATA      = '1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  rq,
  input  logic [ADDR_WIDTH-1:0]                 address,
  input  logic                                  wr_ni,
  input  logic [DATA_WIDTH-1:0]                 dataW,
  output logic                                  ack,
  output logic [DATA_WIDTH-1:0]                 dataR,
  output logic                                  err,
  output logic [NR_OF_SERVERS-1:0]              srv_rq,
  output logic [ADDR_WIDTH-1:0]                 srv_address,
  output logic                                  srv_wr_ni,
  output logic [DATA_WIDTH-1:0]                 srv_dataW,
  input  logic [NR_OF_SERVERS-1:0]              srv_ack,
  input  logic [NR_OF_SERVERS*DATA_WIDTH-1:0]   srv_dataR
);

  localparam int                SEL_W    = width_of(NR_OF_SERVERS);
  localparam int                TMR_W    = width_of(TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t                       state;
  state_t                       state_next;
  logic [TMR_W-1:0]             timer;
  logic [TMR_W-1:0]             timer_next;
  logic                         ack_next;
  logic                         err_next;
  logic [DATA_WIDTH-1:0]        data_r_next;
  logic [NR_OF_SERVERS-1:0]     srv_rq_next;
  logic                         latch;

  logic [SEL_W-1:0]             dec_sel;
  logic                         dec_mapped;
  logic [SEL_W-1:0]             fwd_sel;
  logic                         fwd_ack;
  logic [DATA_WIDTH-1:0]        fwd_data;

  bus_addr_decoder #(
    .NR_OF_SERVERS (NR_OF_SERVERS),
    .SERVER_EN     (SERVER_EN),
    .SEL_W         (SEL_W)
  ) u_decoder (
    .region (address[ADDR_WIDTH-1 -: SEL_W]),
    .sel    (dec_sel),
    .mapped (dec_mapped)
  );

  // The latched address already identifies the server for the whole forward phase
  assign fwd_sel = srv_address[ADDR_WIDTH-1 -: SEL_W];
  assign fwd_ack = srv_ack[fwd_sel];

  // Pick the selected server's read-data slice
  always_comb begin
    fwd_data = '0;
    for (int i = 0; i < NR_OF_SERVERS; i++) begin
      if (fwd_sel == SEL_W'(i)) begin
        fwd_data = srv_dataR[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and next-output logic; every registered output is rebuilt each cycle
  always_comb begin
    state_next  = state;
    timer_next  = timer;
    ack_next    = 1'b0;
    err_next    = 1'b0;
    data_r_next = '0;
    srv_rq_next = '0;
    latch       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rq) begin
          latch      = 1'b1;
          timer_next = '0;
          if (dec_mapped) begin
            state_next           = ST_FWD;
            srv_rq_next[dec_sel] = 1'b1;
          end else begin
            state_next  = ST_RESP;
            ack_next    = 1'b1;
            err_next    = 1'b1;
            data_r_next = ERR_DATA;
          end
        end
      end
      ST_FWD: begin
        // A server ack in the expiry cycle still counts as success
        if (fwd_ack) begin
          state_next  = ST_RESP;
          ack_next    = 1'b1;
          data_r_next = srv_wr_ni ? '0 : fwd_data;
        end else if (timer == TMR_LAST) begin
          state_next  = ST_RESP;
          ack_next    = 1'b1;
          err_next    = 1'b1;
          data_r_next = ERR_DATA;
        end else begin
          timer_next  = timer + TMR_W'(1);
          srv_rq_next = srv_rq;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, timer and registered outputs; reset aborts any transaction silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      ack         <= 1'b0;
      err         <= 1'b0;
      dataR       <= '0;
      srv_rq      <= '0;
      srv_address <= '0;
      srv_wr_ni   <= 1'b0;
      srv_dataW   <= '0;
    end else begin
      state  <= state_next;
      timer  <= timer_next;
      ack    <= ack_next;
      err    <= err_next;
      dataR  <= data_r_next;
      srv_rq <= srv_rq_next;
      if (latch) begin
        srv_address <= address;
        srv_wr_ni   <= wr_ni;
        srv_dataW   <= dataW;
      end
    end
  end

endmodule

// File: tb/tb_bus_splitter.sv
// tb/tb_bus_splitter.sv - directed self-checking bench for bus_splitter
module tb_bus_splitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rq = 1'b0;
  logic        rq_b = 1'b0;
  logic [3:0]  address = '0;
  logic        wr_ni = 1'b0;
  logic [7:0]  dataW = '0;
  logic [3:0]  srv_ack = '0;
  logic [31:0] srv_dataR = '0;
  logic [3:0]  srv_ack_b = '0;
  logic [31:0] srv_dataR_b = '0;

  logic        ack, err, srv_wr_ni;
  logic [7:0]  dataR, srv_dataW;
  logic [3:0]  srv_rq, srv_address;
  logic        ack_b, err_b, srv_wr_ni_b;
  logic [7:0]  dataR_b, srv_dataW_b;
  logic [3:0]  srv_rq_b, srv_address_b;

  int checks = 0;
  int errors = 0;
  int n;
  int hi;

  always #5 clk = ~clk;

  bus_splitter #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .NR_OF_SERVERS(4),
    .SERVER_EN(4'b1111), .TIMEOUT(15), .ERR_DATA(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .rq(rq), .address(address), .wr_ni(wr_ni),
    .dataW(dataW), .ack(ack), .dataR(dataR), .err(err), .srv_rq(srv_rq),
    .srv_address(srv_address), .srv_wr_ni(srv_wr_ni), .srv_dataW(srv_dataW),
    .srv_ack(srv_ack), .srv_dataR(srv_dataR)
  );

  bus_splitter #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .NR_OF_SERVERS(4),
    .SERVER_EN(4'b1011), .TIMEOUT(15), .ERR_DATA(8'hFF)
  ) dut_b (
    .clk(clk), .reset(reset), .rq(rq_b), .address(address), .wr_ni(wr_ni),
    .dataW(dataW), .ack(ack_b), .dataR(dataR_b), .err(err_b), .srv_rq(srv_rq_b),
    .srv_address(srv_address_b), .srv_wr_ni(srv_wr_ni_b), .srv_dataW(srv_dataW_b),
    .srv_ack(srv_ack_b), .srv_dataR(srv_dataR_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // reset state
    @(posedge clk); #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dataR", {24'd0, dataR}, 32'd0);
    chk("rst_srv_rq", {28'd0, srv_rq}, 32'd0);
    chk("rst_srv_fields", {19'd0, srv_address, srv_wr_ni, srv_dataW}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // write 0xA5 to addr 9, server 2 acks with no delay
    rq = 1'b1; address = 4'd9; wr_ni = 1'b1; dataW = 8'hA5;
    step();
    chk("wr_srv_rq", {28'd0, srv_rq}, 32'h4);
    chk("wr_srv_dataW", {24'd0, srv_dataW}, 32'hA5);
    chk("wr_srv_address", {28'd0, srv_address}, 32'd9);
    chk("wr_srv_wr_ni", {31'd0, srv_wr_ni}, 32'd1);
    chk("wr_no_early_ack", {31'd0, ack}, 32'd0);
    srv_ack = 4'b0100;
    srv_dataR[2*8 +: 8] = 8'h99;
    step();
    chk("wr_ack", {31'd0, ack}, 32'd1);
    chk("wr_err", {31'd0, err}, 32'd0);
    chk("wr_dataR", {24'd0, dataR}, 32'd0);
    chk("wr_srv_rq_drop", {28'd0, srv_rq}, 32'd0);
    rq = 1'b0; srv_ack = '0;
    step();
    chk("wr_ack_single", {31'd0, ack}, 32'd0);

    // read addr 3, server 0 answers 0x3C after 3 cycles; server 1 acks spuriously
    rq = 1'b1; address = 4'd3; wr_ni = 1'b0; dataW = 8'h00;
    step();
    chk("rd_srv_rq", {28'd0, srv_rq}, 32'h1);
    srv_ack = 4'b0010;
    srv_dataR = 32'h11223344;
    step();
    chk("rd_wait_rq", {28'd0, srv_rq}, 32'h1);
    srv_ack = '0;
    step();
    chk("rd_unsel_ack_ignored", {31'd0, ack}, 32'd0);
    srv_ack = 4'b0001;
    srv_dataR = 32'h55667700;
    srv_dataR[7:0] = 8'h3C;
    step();
    chk("rd_ack", {31'd0, ack}, 32'd1);
    chk("rd_dataR", {24'd0, dataR}, 32'h3C);
    chk("rd_err", {31'd0, err}, 32'd0);
    rq = 1'b0; srv_ack = '0;
    step();
    chk("rd_ack_single", {31'd0, ack}, 32'd0);

    // disabled region on the second splitter: read addr 8 -> immediate error
    rq_b = 1'b1; address = 4'd8; wr_ni = 1'b0;
    step();
    chk("unm_ack", {31'd0, ack_b}, 32'd1);
    chk("unm_err", {31'd0, err_b}, 32'd1);
    chk("unm_dataR", {24'd0, dataR_b}, 32'hFF);
    chk("unm_srv_rq", {28'd0, srv_rq_b}, 32'd0);
    rq_b = 1'b0;
    step();
    chk("unm_ack_single", {31'd0, ack_b}, 32'd0);
    chk("unm_srv_rq_after", {28'd0, srv_rq_b}, 32'd0);

    // server 1 never acks -> 15 cycles of srv_rq then error
    rq = 1'b1; address = 4'd4; wr_ni = 1'b0;
    n = 0; hi = 0;
    step();
    while (!ack && n < 40) begin
      if (srv_rq == 4'b0010) hi++;
      n++;
      step();
    end
    chk("to_ack", {31'd0, ack}, 32'd1);
    chk("to_rq_cycles", hi, 32'd15);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_dataR", {24'd0, dataR}, 32'hFF);
    chk("to_srv_rq_drop", {28'd0, srv_rq}, 32'd0);
    rq = 1'b0; srv_ack = 4'b0010;
    step();
    chk("to_late_ack1", {31'd0, ack}, 32'd0);
    step();
    chk("to_late_ack2", {31'd0, ack}, 32'd0);
    chk("to_late_srv_rq", {28'd0, srv_rq}, 32'd0);
    srv_ack = '0;

    // ack lands in the expiry cycle -> success with data
    rq = 1'b1; address = 4'hD; wr_ni = 1'b0;
    step();
    repeat (14) step();
    chk("exp_rq_still", {28'd0, srv_rq}, 32'h8);
    chk("exp_no_ack_yet", {31'd0, ack}, 32'd0);
    srv_ack = 4'b1000;
    srv_dataR[3*8 +: 8] = 8'h5A;
    step();
    chk("exp_ack", {31'd0, ack}, 32'd1);
    chk("exp_err", {31'd0, err}, 32'd0);
    chk("exp_dataR", {24'd0, dataR}, 32'h5A);
    rq = 1'b0; srv_ack = '0;
    step();

    // reset in the middle of a forward phase
    rq = 1'b1; address = 4'd6; wr_ni = 1'b1; dataW = 8'h42;
    step();
    chk("rf_srv_rq", {28'd0, srv_rq}, 32'h2);
    #2 reset = 1'b1;
    #1;
    chk("rf_srv_rq_async", {28'd0, srv_rq}, 32'd0);
    chk("rf_fields_async", {19'd0, srv_address, srv_wr_ni, srv_dataW}, 32'd0);
    chk("rf_ack_async", {31'd0, ack}, 32'd0);
    @(negedge clk);
    reset = 1'b0; rq = 1'b0; srv_ack = 4'b0010;
    step();
    chk("rf_no_ack", {31'd0, ack}, 32'd0);
    chk("rf_no_srv_rq", {28'd0, srv_rq}, 32'd0);
    srv_ack = '0;

    // normal write after reset, then back-to-back read with rq held through ack
    rq = 1'b1; address = 4'hE; wr_ni = 1'b1; dataW = 8'h11;
    step();
    chk("bb_srv_rq1", {28'd0, srv_rq}, 32'h8);
    chk("bb_srv_dataW", {24'd0, srv_dataW}, 32'h11);
    srv_ack = 4'b1000;
    step();
    chk("bb_ack1", {31'd0, ack}, 32'd1);
    address = 4'd2; wr_ni = 1'b0; srv_ack = '0;
    step();
    chk("bb_gap_ack", {31'd0, ack}, 32'd0);
    chk("bb_gap_srv_rq", {28'd0, srv_rq}, 32'd0);
    step();
    chk("bb_srv_rq2", {28'd0, srv_rq}, 32'h1);
    chk("bb_srv_address2", {28'd0, srv_address}, 32'd2);
    srv_ack = 4'b0001;
    srv_dataR[7:0] = 8'h77;
    step();
    chk("bb_ack2", {31'd0, ack}, 32'd1);
    chk("bb_dataR2", {24'd0, dataR}, 32'h77);
    rq = 1'b0; srv_ack = '0;
    step();
    chk("bb_end_ack", {31'd0, ack}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
